// File: rtl/gs_pkg.sv
// Shared types for the gs memory arbiter: FSM states, access owner and the
// latched request payload that drives the SRAM pins.
package gs_pkg;

  localparam int unsigned GS_ADDR_SIZE = 32;
  localparam int unsigned GS_WORD_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } arb_owner_e;

  typedef struct packed {
    logic                    we;
    logic [3:0]              be;
    logic [GS_ADDR_SIZE-1:0] addr;
    logic [GS_WORD_SIZE-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/gs_mem_arb_sel.sv
// Winner select between IF and LSU, with the starvation counter that forces
// an IF grant after STARVE_MAX back-to-back LSU grants while IF waits.
module gs_mem_arb_sel
  import gs_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arb_en,
  input  logic                              if_req_i,
  input  logic                              lsu_req_i,
  output logic                              if_win,
  output logic                              lsu_win,
  output logic [$clog2(STARVE_MAX+1)-1:0]   starve_cnt
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  always_comb begin
    lsu_win = lsu_req_i && !(if_req_i && (starve_cnt == CNT_MAX));
    if_win  = if_req_i && !lsu_win;
  end

  // Counts only while IF is actually waiting; any idle IF cycle forgives the debt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req_i) begin
      starve_cnt <= '0;
    end else if (arb_en && if_win) begin
      starve_cnt <= '0;
    end else if (arb_en && lsu_win && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gs_mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the LSU. Read data is
// sampled on the edge that enters RESP, so rvalid is high RD_LAT+1 cycles after gnt.
module gs_mem_arbiter
  import gs_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = GS_ADDR_SIZE,
  parameter int unsigned WORD_SIZE  = GS_WORD_SIZE,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req_i,
  input  logic [ADDR_SIZE-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [WORD_SIZE-1:0] if_rdata_o,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [3:0]           lsu_be_i,
  input  logic [ADDR_SIZE-1:0] lsu_addr_i,
  input  logic [WORD_SIZE-1:0] lsu_wdata_i,
  output logic                 lsu_gnt_o,
  output logic                 lsu_rvalid_o,
  output logic [WORD_SIZE-1:0] lsu_rdata_o,
  output logic                 mem_oe_o,
  output logic [3:0]           mem_web_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  input  logic [WORD_SIZE-1:0] mem_data_i,
  output logic                 arb_busy_o
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e state;
  arb_owner_e owner;
  logic [CNT_W-1:0] rd_cnt;
  logic [$clog2(STARVE_MAX+1)-1:0] starve_cnt;
  logic arb_en, if_win, lsu_win, rd_capture;
  mem_req_t win_req;

  assign arb_en = (state == IDLE);

  gs_mem_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .if_req_i   (if_req_i),
    .lsu_req_i  (lsu_req_i),
    .if_win     (if_win),
    .lsu_win    (lsu_win),
    .starve_cnt (starve_cnt)
  );

  // Grants are gated by reset so every output reads 0 while rst is held low.
  assign if_gnt_o   = rst && arb_en && if_win;
  assign lsu_gnt_o  = rst && arb_en && lsu_win;
  assign arb_busy_o = (state != IDLE);

  always_comb begin
    win_req      = '0;
    win_req.addr = if_addr_i;
    if (lsu_win) begin
      win_req.we    = lsu_we_i;
      win_req.be    = lsu_be_i;
      win_req.addr  = lsu_addr_i;
      win_req.wdata = lsu_wdata_i;
    end
  end

  // mem_oe_o is only ever set in ISSUE for reads, so it doubles as the read flag there.
  assign rd_capture = ((state == ISSUE) && mem_oe_o && (RD_LAT == 1)) ||
                      ((state == WAIT) && (rd_cnt == CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      rd_cnt       <= '0;
      mem_oe_o     <= 1'b0;
      mem_web_o    <= 4'h0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      if_rvalid_o  <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      if_rdata_o   <= '0;
      lsu_rdata_o  <= '0;
    end else begin
      if_rvalid_o  <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win || lsu_win) begin
            state      <= ISSUE;
            owner      <= lsu_win ? OWN_LSU : OWN_IF;
            mem_oe_o   <= !win_req.we;
            mem_web_o  <= win_req.we ? win_req.be : 4'h0;
            mem_addr_o <= win_req.addr;
            mem_data_o <= win_req.wdata;
          end
        end
        ISSUE: begin
          mem_oe_o  <= 1'b0;
          mem_web_o <= 4'h0;
          if (!mem_oe_o) begin
            state <= IDLE;
          end else if (rd_capture) begin
            state <= RESP;
          end else begin
            state  <= WAIT;
            rd_cnt <= CNT_W'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (rd_capture) begin
            state <= RESP;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (rd_capture) begin
        if (owner == OWN_LSU) begin
          lsu_rdata_o  <= mem_data_i;
          lsu_rvalid_o <= 1'b1;
        end else begin
          if_rdata_o  <= mem_data_i;
          if_rvalid_o <= 1'b1;
        end
      end
    end
  end

  // A requester must hold its request until granted.
  a_if_hold: assert property (@(posedge clk) disable iff (!rst)
    (if_req_i && !if_gnt_o) |=> if_req_i);
  a_lsu_hold: assert property (@(posedge clk) disable iff (!rst)
    (lsu_req_i && !lsu_gnt_o) |=> lsu_req_i);

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Directed bench for gs_mem_arbiter: main instance at RD_LAT=2 plus RD_LAT=1/3 instances for the latency sweep.
module tb_gs_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, lsu_req, lsu_we;
  logic [31:0] if_addr, lsu_addr, lsu_wdata, mem_rdata, rd_word;
  logic [3:0]  lsu_be;
  logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_oe, busy;
  logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_web;

  // Sweep instances: LSU loads only
  logic        l1_req, l3_req;
  logic [31:0] sw_addr, sw_word, l1_mem_rdata, l3_mem_rdata;
  logic        l1_if_gnt, l1_if_rvalid, l1_gnt, l1_rvalid, l1_oe, l1_busy;
  logic [31:0] l1_if_rdata, l1_rdata, l1_mem_addr, l1_mem_wdata;
  logic [3:0]  l1_web;
  logic        l3_if_gnt, l3_if_rvalid, l3_gnt, l3_rvalid, l3_oe, l3_busy;
  logic [31:0] l3_if_rdata, l3_rdata, l3_mem_addr, l3_mem_wdata;
  logic [3:0]  l3_web;

  int n_tests = 0;
  int n_fail  = 0;
  int age  = 0;
  int age3 = 0;

  // SRAM models: data is valid only in the cycle it is due, X otherwise.
  always @(posedge clk) age  <= mem_oe ? 1 : ((age  != 0 && age  < 7) ? age  + 1 : 0);
  always @(posedge clk) age3 <= l3_oe  ? 1 : ((age3 != 0 && age3 < 7) ? age3 + 1 : 0);
  assign mem_rdata    = (age == 1)  ? rd_word : 'x;
  assign l1_mem_rdata = l1_oe       ? sw_word : 'x;
  assign l3_mem_rdata = (age3 == 2) ? sw_word : 'x;

  gs_mem_arbiter #(.RD_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_be_i(lsu_be),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .mem_oe_o(mem_oe), .mem_web_o(mem_web), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .arb_busy_o(busy)
  );

  gs_mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0), .if_gnt_o(l1_if_gnt),
    .if_rvalid_o(l1_if_rvalid), .if_rdata_o(l1_if_rdata),
    .lsu_req_i(l1_req), .lsu_we_i(1'b0), .lsu_be_i(4'h0),
    .lsu_addr_i(sw_addr), .lsu_wdata_i(32'h0), .lsu_gnt_o(l1_gnt),
    .lsu_rvalid_o(l1_rvalid), .lsu_rdata_o(l1_rdata),
    .mem_oe_o(l1_oe), .mem_web_o(l1_web), .mem_addr_o(l1_mem_addr),
    .mem_data_o(l1_mem_wdata), .mem_data_i(l1_mem_rdata), .arb_busy_o(l1_busy)
  );

  gs_mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut_l3 (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0), .if_gnt_o(l3_if_gnt),
    .if_rvalid_o(l3_if_rvalid), .if_rdata_o(l3_if_rdata),
    .lsu_req_i(l3_req), .lsu_we_i(1'b0), .lsu_be_i(4'h0),
    .lsu_addr_i(sw_addr), .lsu_wdata_i(32'h0), .lsu_gnt_o(l3_gnt),
    .lsu_rvalid_o(l3_rvalid), .lsu_rdata_o(l3_rdata),
    .mem_oe_o(l3_oe), .mem_web_o(l3_web), .mem_addr_o(l3_mem_addr),
    .mem_data_o(l3_mem_wdata), .mem_data_i(l3_mem_rdata), .arb_busy_o(l3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
    lsu_be = 4'h0; lsu_addr = '0; lsu_wdata = '0; rd_word = '0;
    l1_req = 1'b0; l3_req = 1'b0; sw_addr = '0; sw_word = '0;

    // Reset state, with a request present that must not be granted
    tick(); lsu_req = 1'b1;
    settle();
    chk("rst_lsu_gnt", lsu_gnt, 0);   chk("rst_if_gnt", if_gnt, 0);
    chk("rst_busy", busy, 0);         chk("rst_oe", mem_oe, 0);
    chk("rst_web", mem_web, 0);       chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);   chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_lsu_rvalid", lsu_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_lsu_rdata", lsu_rdata, 0);
    lsu_req = 1'b0;
    tick(); rst = 1'b1;

    // 1: LSU load 0x100
    tick(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100; rd_word = 32'hDEADBEEF;
    settle(); chk("t1_gnt", lsu_gnt, 1); chk("t1_if_gnt", if_gnt, 0); chk("t1_busy_T", busy, 0);
    tick(); lsu_req = 1'b0;
    settle(); chk("t1_oe", mem_oe, 1); chk("t1_web", mem_web, 0);
    chk("t1_addr", mem_addr, 32'h100); chk("t1_busy", busy, 1); chk("t1_gnt_off", lsu_gnt, 0);
    tick(); settle(); chk("t1_wait_oe", mem_oe, 0); chk("t1_wait_addr", mem_addr, 32'h100);
    chk("t1_early_rvalid", lsu_rvalid, 0);
    tick(); settle(); chk("t1_rvalid", lsu_rvalid, 1); chk("t1_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("t1_if_rvalid", if_rvalid, 0);
    tick(); settle(); chk("t1_rvalid_pulse", lsu_rvalid, 0); chk("t1_idle", busy, 0);
    chk("t1_rdata_hold", lsu_rdata, 32'hDEADBEEF);

    // 2: LSU store be=3 to 0x40
    tick(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'h3; lsu_addr = 32'h40; lsu_wdata = 32'h0000ABCD;
    settle(); chk("t2_gnt", lsu_gnt, 1);
    tick(); lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0;
    settle(); chk("t2_web", mem_web, 4'h3); chk("t2_oe", mem_oe, 0);
    chk("t2_addr", mem_addr, 32'h40); chk("t2_wdata", mem_wdata, 32'h0000ABCD); chk("t2_busy", busy, 1);
    tick(); settle(); chk("t2_web_off", mem_web, 0); chk("t2_idle", busy, 0); chk("t2_no_rvalid", lsu_rvalid, 0);
    tick(); settle(); chk("t2_no_rvalid2", lsu_rvalid, 0); chk("t2_rdata_hold", lsu_rdata, 32'hDEADBEEF);

    // Store with be=0 is a granted no-op
    tick(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'h0; lsu_addr = 32'h44; lsu_wdata = 32'hFFFFFFFF;
    settle(); chk("be0_gnt", lsu_gnt, 1);
    tick(); lsu_req = 1'b0; lsu_we = 1'b0;
    settle(); chk("be0_web", mem_web, 0); chk("be0_oe", mem_oe, 0); chk("be0_busy", busy, 1);
    tick(); settle(); chk("be0_idle", busy, 0);

    // 3: simultaneous requests, LSU wins, IF served next
    tick(); if_req = 1'b1; if_addr = 32'h200;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h48; lsu_wdata = 32'h11223344;
    settle(); chk("t3_lsu_gnt", lsu_gnt, 1); chk("t3_if_gnt", if_gnt, 0);
    tick(); lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0;
    settle(); chk("t3_if_gnt_issue", if_gnt, 0); chk("t3_web", mem_web, 4'hF);
    tick(); rd_word = 32'hCAFEF00D;
    settle(); chk("t3_if_gnt2", if_gnt, 1); chk("t3_lsu_gnt2", lsu_gnt, 0);
    chk("t3_cnt1", 32'(dut.u_sel.starve_cnt), 1);
    tick(); if_req = 1'b0;
    settle(); chk("t3_oe", mem_oe, 1); chk("t3_addr", mem_addr, 32'h200);
    chk("t3_cnt0", 32'(dut.u_sel.starve_cnt), 0);
    tick(); settle(); chk("t3_early", if_rvalid, 0);
    tick(); settle(); chk("t3_if_rvalid", if_rvalid, 1); chk("t3_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("t3_lsu_rvalid", lsu_rvalid, 0); chk("t3_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
    tick(); settle(); chk("t3_pulse", if_rvalid, 0); chk("t3_idle", busy, 0);

    // 4: starvation: 4 LSU stores, then IF forced
    tick(); if_req = 1'b1; if_addr = 32'h300; rd_word = 32'h12345678;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'hF; lsu_addr = 32'h80; lsu_wdata = 32'hA0A0A0A0;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("t4_lsu_gnt", lsu_gnt, 1); chk("t4_if_gnt", if_gnt, 0);
      chk("t4_cnt", 32'(dut.u_sel.starve_cnt), i);
      tick(); settle(); chk("t4_issue_gnt", lsu_gnt, 0);
      tick();
    end
    settle(); chk("t4_if_forced", if_gnt, 1); chk("t4_lsu_held", lsu_gnt, 0);
    chk("t4_cnt_max", 32'(dut.u_sel.starve_cnt), 4);
    tick(); if_req = 1'b0;
    settle(); chk("t4_oe", mem_oe, 1); chk("t4_addr", mem_addr, 32'h300);
    chk("t4_cnt_clr", 32'(dut.u_sel.starve_cnt), 0);
    tick(); settle();
    tick(); settle(); chk("t4_if_rvalid", if_rvalid, 1); chk("t4_if_rdata", if_rdata, 32'h12345678);
    tick(); settle(); chk("t4_lsu_after", lsu_gnt, 1);
    tick(); lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'h0;
    settle(); chk("t4_lsu_web", mem_web, 4'hF);
    tick();

    // 5: async reset during WAIT of an IF read
    if_req = 1'b1; if_addr = 32'h400; rd_word = 32'h55AA55AA;
    settle(); chk("t5_gnt", if_gnt, 1);
    tick(); if_req = 1'b0;
    settle(); chk("t5_oe", mem_oe, 1);
    tick(); settle(); chk("t5_wait_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0); chk("t5_oe0", mem_oe, 0); chk("t5_addr", mem_addr, 0);
    chk("t5_web", mem_web, 0); chk("t5_if_rvalid", if_rvalid, 0); chk("t5_if_rdata", if_rdata, 0);
    tick(); tick(); rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle(); chk("t5_no_rvalid", if_rvalid, 0); chk("t5_idle", busy, 0);
      tick();
    end
    if_req = 1'b1; if_addr = 32'h404; rd_word = 32'h0F0F0F0F;
    settle(); chk("t5_regnt", if_gnt, 1);
    tick(); if_req = 1'b0;
    settle(); chk("t5_readdr", mem_addr, 32'h404);
    tick(); settle();
    tick(); settle(); chk("t5_rvalid", if_rvalid, 1); chk("t5_rdata", if_rdata, 32'h0F0F0F0F);

    // 6: RD_LAT=1 and 3, back-to-back loads with request held
    tick(); l1_req = 1'b1; l3_req = 1'b1; sw_addr = 32'h500; sw_word = 32'h13579BDF;
    for (int c = 0; c <= 10; c++) begin
      settle();
      chk("t6_l1_gnt", l1_gnt, (c == 0 || c == 3));
      chk("t6_l1_rvalid", l1_rvalid, (c == 2 || c == 5));
      chk("t6_l3_gnt", l3_gnt, (c == 0 || c == 5));
      chk("t6_l3_rvalid", l3_rvalid, (c == 4 || c == 9));
      if (c == 2 || c == 5) chk("t6_l1_rdata", l1_rdata, 32'h13579BDF);
      if (c == 4 || c == 9) chk("t6_l3_rdata", l3_rdata, 32'h13579BDF);
      tick();
      if (c == 3) l1_req = 1'b0;
      if (c == 5) l3_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
